// File: rtl/cpu_clk_pkg.sv
// Shared types for the CPU clock-enable generator: FSM states, turbo level type
// and the per-level CPU enable period mask.
package cpu_clk_pkg;

  typedef enum logic [1:0] {ST_RUN, ST_SETTLE, ST_STALL} cpu_state_t;

  typedef logic [2:0] level_t;

  localparam int MASK_W = 16;

  // Low (max_div - level) bits set: CPU enable period minus one at this level.
  function automatic logic [MASK_W-1:0] period_mask(input level_t level, input int max_div);
    logic [MASK_W-1:0] one;
    one = MASK_W'(1);
    return (one << (max_div - int'(level))) - one;
  endfunction

endpackage

// File: rtl/cpu_clk_gen_ce_div.sv
// Master divider: free-running counter and registered 1-cycle enable strobes.
// Latency: every strobe asserts the cycle after its counter match; no backpressure.
module ce_div
  import cpu_clk_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [CNT_W-1:0] cpu_mask,
  input  logic             cpu_gate,
  output logic             cpu_tn,
  output logic             ce_28m,
  output logic             ce_7mp,
  output logic             ce_7mn,
  output logic             ce_psg,
  output logic             ce_cpu_p,
  output logic             ce_cpu_n
);

  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] cpu_half;
  logic             cpu_tp;

  // Mask is always 2^k-1 with k>=1, so the n phase sits exactly half a period after p.
  assign cpu_half = (cpu_mask >> 1) + CNT_W'(1);
  assign cpu_tp   = (counter & cpu_mask) == '0;
  assign cpu_tn   = (counter & cpu_mask) == cpu_half;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      counter  <= '0;
      ce_28m   <= 1'b0;
      ce_7mp   <= 1'b0;
      ce_7mn   <= 1'b0;
      ce_psg   <= 1'b0;
      ce_cpu_p <= 1'b0;
      ce_cpu_n <= 1'b0;
    end else begin
      counter  <= counter + CNT_W'(1);
      ce_28m   <= counter[1:0] == 2'd0;
      ce_7mp   <= counter[3:0] == 4'd0;
      ce_7mn   <= counter[3:0] == 4'd8;
      ce_psg   <= counter == '0;
      ce_cpu_p <= cpu_gate & cpu_tp;
      ce_cpu_n <= cpu_gate & cpu_tn;
    end
  end

endmodule

// File: rtl/cpu_clk_gen.sv
// Clock-enable and turbo generator; speed changes halt the CPU, settle, then resume.
// Latency: strobes 1 cycle after counter match; mem_ready stalls CPU at fast levels; optional wait_n via CPU_CLK_GEN_WAIT_EN.
module cpu_clk_gen
  import cpu_clk_pkg::*;
#(
  parameter int CNT_W       = 6,
  parameter int MAX_DIV     = 5,
  parameter int LEVELS      = 5,
  parameter int SETTLE      = 3,
  parameter int STALL_LEVEL = 3
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [2:0] level_req,
  input  logic       slow_force,
  input  logic       mem_ready,
`ifdef CPU_CLK_GEN_WAIT_EN
  input  logic       wait_n,
`endif
  output logic       ce_28m,
  output logic       ce_7mp,
  output logic       ce_7mn,
  output logic       ce_psg,
  output logic       ce_cpu_p,
  output logic       ce_cpu_n,
  output logic       ce_cpu,
  output logic [2:0] cur_level,
  output logic       switching
);

  localparam level_t     LVL_MAX     = level_t'(LEVELS - 1);
  localparam level_t     LVL_STALL   = level_t'(STALL_LEVEL);
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE);

  cpu_state_t       state, state_nxt;
  level_t           level_nxt, eff;
  logic [3:0]       settle_cnt, settle_nxt;
  logic [CNT_W-1:0] cpu_mask;
  logic             cpu_en, cpu_gate, cpu_tn, changed;

  assign eff      = slow_force ? level_t'(0) : ((level_req > LVL_MAX) ? LVL_MAX : level_req);
  assign changed  = eff != cur_level;
  assign cpu_en   = state == ST_RUN;
  assign cpu_mask = CNT_W'(period_mask(cur_level, MAX_DIV));

`ifdef CPU_CLK_GEN_WAIT_EN
  assign cpu_gate = cpu_en & wait_n;
`else
  assign cpu_gate = cpu_en;
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= ST_SETTLE;
      cur_level  <= '0;
      settle_cnt <= SETTLE_INIT;
    end else begin
      state      <= state_nxt;
      cur_level  <= level_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  // Decisions only on the n phase so a mask change never splits a p/n pair.
  always_comb begin
    state_nxt  = state;
    level_nxt  = cur_level;
    settle_nxt = settle_cnt;
    if (cpu_tn) begin
      if (changed) begin
        state_nxt  = ST_SETTLE;
        level_nxt  = eff;
        settle_nxt = SETTLE_INIT;
      end else begin
        case (state)
          ST_RUN: begin
            if ((cur_level >= LVL_STALL) && !mem_ready) state_nxt = ST_STALL;
          end
          ST_SETTLE: begin
            if (settle_cnt != 4'd0) settle_nxt = settle_cnt - 4'd1;
            else if (mem_ready)     state_nxt  = ST_RUN;
          end
          ST_STALL: begin
            if (mem_ready) state_nxt = ST_RUN;
          end
          default: state_nxt = ST_SETTLE;
        endcase
      end
    end
  end

  assign switching = state == ST_SETTLE;
  assign ce_cpu    = ce_cpu_p;

  ce_div #(
    .CNT_W (CNT_W)
  ) u_ce_div (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .cpu_mask (cpu_mask),
    .cpu_gate (cpu_gate),
    .cpu_tn   (cpu_tn),
    .ce_28m   (ce_28m),
    .ce_7mp   (ce_7mp),
    .ce_7mn   (ce_7mn),
    .ce_psg   (ce_psg),
    .ce_cpu_p (ce_cpu_p),
    .ce_cpu_n (ce_cpu_n)
  );

endmodule
